// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid buffer for a valid/ready pipeline stage.
// in_ready_o is a flop, so out_ready_i never reaches the upstream port
// through logic. The head is always in the main register; the skid register
// only absorbs the one beat accepted while downstream was stalled.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   flush_i      synchronous kill of all held entries
//   in_valid_i   upstream valid
//   in_ready_o   upstream may transfer (registered)
//   in_data_i    upstream payload
//   out_valid_o  out_data_o holds a live entry
//   out_ready_i  downstream accepts
//   out_data_o   head entry, straight from the main register
//   count_o      entries held (0, 1 or 2)
module pipe_skid_reg #(
   parameter int unsigned     DW      = 32,
   parameter logic [DW-1:0]   RST_VAL = DW'(32'h0000_0013)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [DW-1:0] in_data_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [DW-1:0] out_data_o,
   output logic [1:0]    count_o
);

   // State code equals the number of held entries.
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] BUSY  = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] main_q, main_d;
   logic [DW-1:0] skid_q, skid_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          in_fire, out_fire;

   assign in_fire     = in_valid_i & in_ready_q;
   assign out_fire    = out_valid_q & out_ready_i;

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = main_q;
   assign count_o     = state_q;

   // Next-state and datapath update; flush overrides every fire event.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               main_d  = in_data_i;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (in_fire && out_fire) begin
               main_d = in_data_i;
            end else if (in_fire) begin
               skid_d  = in_data_i;
               state_d = FULL;
            end else if (out_fire) begin
               main_d  = RST_VAL;
               state_d = EMPTY;
            end
         end
         FULL: begin
            // in_ready_q is low here, so only the drain side can fire.
            if (out_fire) begin
               main_d  = skid_q;
               skid_d  = RST_VAL;
               state_d = BUSY;
            end
         end
         default: begin
            state_d = EMPTY;
            main_d  = RST_VAL;
            skid_d  = RST_VAL;
         end
      endcase

      if (flush_i) begin
         state_d = EMPTY;
         main_d  = RST_VAL;
         skid_d  = RST_VAL;
      end

      in_ready_d  = (state_d != FULL);
      out_valid_d = (state_d != EMPTY);
   end

   // State and data registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= EMPTY;
         main_q      <= RST_VAL;
         skid_q      <= RST_VAL;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: reset, streaming, backpressure, flush,
// drain and reset-in-FULL, with hand-computed expected values.
module tb_pipe_skid_reg;

   localparam int unsigned DW = 32;

   logic          clk;
   logic          rst;
   logic          flush_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [DW-1:0] in_data_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [DW-1:0] out_data_o;
   logic [1:0]    count_o;

   int vectors;
   int miscompares;

   pipe_skid_reg #(.DW(DW), .RST_VAL(32'h0000_0013)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .count_o     (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock edge; outputs settle 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [1:0] cnt, input logic vld,
                            input logic rdy, input logic [31:0] data);
      chk({tag, ".count"}, 32'(count_o), 32'(cnt));
      chk({tag, ".valid"}, 32'(out_valid_o), 32'(vld));
      chk({tag, ".ready"}, 32'(in_ready_o), 32'(rdy));
      chk({tag, ".data"},  out_data_o, data);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      flush_i     = 1'b0;
      in_valid_i  = 1'b0;
      in_data_i   = '0;
      out_ready_i = 1'b0;

      // Reset
      #2;
      step();
      rst = 1'b1;
      chk_state("reset", 2'd0, 1'b0, 1'b1, 32'h13);

      // Streaming with downstream always ready
      out_ready_i = 1'b1;
      in_valid_i  = 1'b1;
      in_data_i   = 32'hA;
      step();
      chk_state("stream_a", 2'd1, 1'b1, 1'b1, 32'hA);
      in_data_i = 32'hB;
      step();
      chk_state("stream_b", 2'd1, 1'b1, 1'b1, 32'hB);
      in_data_i = 32'hC;
      step();
      chk_state("stream_c", 2'd1, 1'b1, 1'b1, 32'hC);
      in_valid_i = 1'b0;
      step();
      chk_state("stream_drain", 2'd0, 1'b0, 1'b1, 32'h13);

      // Backpressure: 0x33 must wait upstream while FULL
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_data_i   = 32'h11;
      step();
      chk_state("bp_11", 2'd1, 1'b1, 1'b1, 32'h11);
      in_data_i = 32'h22;
      step();
      chk_state("bp_22", 2'd2, 1'b1, 1'b0, 32'h11);
      in_data_i = 32'h33;
      step();
      chk_state("bp_hold", 2'd2, 1'b1, 1'b0, 32'h11);
      out_ready_i = 1'b1;
      step();
      chk_state("bp_out22", 2'd1, 1'b1, 1'b1, 32'h22);
      step();
      chk_state("bp_out33", 2'd1, 1'b1, 1'b1, 32'h33);
      in_valid_i = 1'b0;
      step();
      chk_state("bp_empty", 2'd0, 1'b0, 1'b1, 32'h13);

      // Flush while FULL with an offered beat
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_data_i   = 32'h66;
      step();
      in_data_i = 32'h77;
      step();
      chk("fl_full.count", 32'(count_o), 32'd2);
      flush_i   = 1'b1;
      in_data_i = 32'h44;
      step();
      chk_state("flush", 2'd0, 1'b0, 1'b1, 32'h13);
      flush_i    = 1'b0;
      in_valid_i = 1'b0;
      step();
      chk_state("flush_after", 2'd0, 1'b0, 1'b1, 32'h13);
      // Skid must have been cleared: a fresh entry drains straight to empty.
      in_valid_i = 1'b1;
      in_data_i  = 32'h88;
      step();
      chk_state("post_fl_88", 2'd1, 1'b1, 1'b1, 32'h88);
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      step();
      chk_state("post_fl_empty", 2'd0, 1'b0, 1'b1, 32'h13);

      // Drain from BUSY holding 0x55
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_data_i   = 32'h55;
      step();
      chk_state("drain_busy", 2'd1, 1'b1, 1'b1, 32'h55);
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      step();
      chk_state("drain", 2'd0, 1'b0, 1'b1, 32'h13);

      // Reset in FULL, with flush and handshakes active at the same edge
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_data_i   = 32'h99;
      step();
      in_data_i = 32'hAA;
      step();
      chk("rf_full.count", 32'(count_o), 32'd2);
      rst         = 1'b0;
      flush_i     = 1'b1;
      out_ready_i = 1'b1;
      in_data_i   = 32'hBB;
      step();
      chk_state("rst_full", 2'd0, 1'b0, 1'b1, 32'h13);
      rst        = 1'b1;
      flush_i    = 1'b0;
      in_valid_i = 1'b0;
      step();
      chk_state("rst_after", 2'd0, 1'b0, 1'b1, 32'h13);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DW, default 32: payload width in bits.
REQ-002 SHALL have parameter RST_VAL, default 32'h0000_0013: value loaded into every data register on reset, flush and drain (pipeline NOP).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  synchronous kill of all held entries.
REQ-006 SHALL have port in_valid_i  input  1  upstream data valid.
REQ-007 SHALL have port in_ready_o  output  1  block can accept data; registered.
REQ-008 SHALL have port in_data_i  input  DW  upstream payload.
REQ-009 SHALL have port out_valid_o  output  1  out_data_o holds a live entry.
REQ-010 SHALL have port out_ready_i  input  1  downstream accepts.
REQ-011 SHALL have port out_data_o  output  DW  head entry; driven directly from the main register.
REQ-012 SHALL have port count_o  output  2  entries held (0, 1 or 2).

Function
REQ-013 SHALL define in_fire = in_valid_i & in_ready_o and out_fire = out_valid_o & out_ready_i.
REQ-014 SHALL hold a main register (head) and a skid register, both DW wide.
REQ-015 SHALL implement states EMPTY (0 entries), BUSY (1), FULL (2); count_o SHALL equal 0/1/2 respectively.
REQ-016 SHALL drive out_valid_o = 1 in BUSY and FULL, and 0 in EMPTY.
REQ-017 SHALL drive in_ready_o = 1 in EMPTY and BUSY, and 0 in FULL, from a flop (no combinational path from out_ready_i).
REQ-018 In EMPTY with in_fire, SHALL load main <= in_data_i and enter BUSY; otherwise remain in EMPTY.
REQ-019 In BUSY with in_fire & out_fire, SHALL load main <= in_data_i and stay in BUSY (full throughput, no bubble).
REQ-020 In BUSY with in_fire & !out_fire, SHALL load skid <= in_data_i and enter FULL.
REQ-021 In BUSY with out_fire & !in_fire, SHALL load main <= RST_VAL and enter EMPTY.
REQ-022 In FULL with out_fire, SHALL load main <= skid, skid <= RST_VAL and enter BUSY; in_fire cannot occur in FULL.
REQ-023 With neither fire event, all registers and state SHALL hold.
REQ-024 Entries SHALL leave in acceptance order; no entry is dropped or duplicated except by flush or reset.
REQ-025 flush_i = 1 SHALL, at the next edge, force EMPTY with main = skid = RST_VAL and in_ready_o = 1, overriding every fire event in that cycle; an in_fire in the flush cycle is discarded.
REQ-026 out_data_o SHALL equal RST_VAL whenever state is EMPTY.
REQ-027 Latency from in_fire to out_valid_o SHALL be exactly 1 cycle.

Reset
REQ-028 rst = 0 at a clock edge SHALL force EMPTY, main = skid = RST_VAL, in_ready_o = 1, out_valid_o = 0, count_o = 0, with priority over flush_i and all handshakes.
REQ-029 Reset asserted mid-operation (BUSY or FULL) SHALL discard all held entries identically to REQ-028.
REQ-030 No output SHALL be X after the first reset edge.

Verification (DW = 32, RST_VAL = 32'h13)
REQ-031 Reset: rst = 0 one cycle, then 1 -> out_valid_o = 0, out_data_o = 0x13, in_ready_o = 1, count_o = 0.
REQ-032 Streaming: out_ready_i = 1, push 0xA, 0xB, 0xC on consecutive cycles -> out_data_o shows 0xA, 0xB, 0xC on the following consecutive cycles, count_o stays 1, in_ready_o never drops.
REQ-033 Backpressure: out_ready_i = 0, offer 0x11, 0x22, 0x33 -> 0x11 and 0x22 accepted, count_o = 2, in_ready_o = 0, 0x33 held upstream. Then out_ready_i = 1 -> outputs 0x11, 0x22, 0x33 in order, no loss.
REQ-034 Flush in FULL with in_valid_i = 1 and in_data_i = 0x44 -> next cycle count_o = 0, out_valid_o = 0, out_data_o = 0x13, and 0x44 never appears.
REQ-035 Drain: BUSY holding 0x55, out_ready_i = 1, in_valid_i = 0 -> next cycle EMPTY and out_data_o = 0x13.
REQ-036 Reset in FULL with flush_i = 1 and in_valid_i = 1 simultaneously -> response identical to REQ-031.
